// File: rtl/scaler_h_sched_if.sv
// Pixel source stream into the horizontal-scaler sequencer.
// The source side drives data/valid; the sequencer answers with ready.
interface scaler_h_sched_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic [PIXEL_WIDTH-1:0] src_data;
  logic                   src_valid;
  logic                   src_ready;

  modport master (
    output src_data,
    output src_valid,
    input  src_ready
  );

  modport slave (
    input  src_data,
    input  src_valid,
    output src_ready
  );
endinterface

// File: rtl/scaler_h_sched.sv
// Frame/line sequencer feeding the horizontal scaler input stream.
// Pulls pixels from a valid/ready source with a programmable per-pixel gap,
// inserts inter-line blanking, produces hs/vs framing and owns the
// frame-synchronous scale step.
module scaler_h_sched #(
  parameter int PIXEL_WIDTH = 8,
  parameter int DIM_WIDTH   = 12,
  parameter int VS_LEAD     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wr,
  input  logic [DIM_WIDTH-1:0]   cfg_w,
  input  logic [DIM_WIDTH-1:0]   cfg_h,
  input  logic [3:0]             cfg_gap,
  input  logic [7:0]             cfg_hblank,
  input  logic [15:0]            cfg_step,
  input  logic                   start,
  scaler_h_sched_if.slave        src,
  output logic [PIXEL_WIDTH-1:0] di_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic [15:0]            scale_step_h,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int LW = (VS_LEAD > 1) ? $clog2(VS_LEAD) : 1;
  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VLEAD,
    S_HS,
    S_PIX,
    S_HBLANK,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // Shadow (host-written) and active (frame-latched) configuration
  logic [DIM_WIDTH-1:0] sh_w, sh_h, act_w, act_h;
  logic [3:0]           sh_gap, act_gap;
  logic [7:0]           sh_hb, act_hb;
  logic [15:0]          sh_step;

  logic [DIM_WIDTH-1:0] pix_cnt, line_cnt;
  logic [3:0]           gap_cnt;
  logic [7:0]           blank_cnt;
  logic [LW-1:0]        lead_cnt;

  logic accept, fire, ready, last_line;

  assign last_line = ({1'b0, line_cnt} + {{DIM_WIDTH{1'b0}}, 1'b1}) >= {1'b0, act_h};

  // Next-state and handshake decode
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fire     = 1'b0;
    ready    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && (sh_w != '0) && (sh_h != '0)) begin
          accept   = 1'b1;
          state_nx = S_VLEAD;
        end
      end
      S_VLEAD: begin
        if (lead_cnt == '0) state_nx = S_HS;
      end
      S_HS: state_nx = S_PIX;
      S_PIX: begin
        ready = (gap_cnt == '0) && (pix_cnt < act_w);
        fire  = ready && src.src_valid;
        if (fire && ((pix_cnt + DIM_ONE) == act_w)) state_nx = S_HBLANK;
      end
      S_HBLANK: begin
        if (blank_cnt == '0) state_nx = last_line ? S_DONE : S_HS;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign src.src_ready = ready;
  assign hs_o          = (state == S_HS);
  assign frame_done    = (state == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Configuration, counters and registered scaler-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_w         <= '0;
      sh_h         <= '0;
      sh_gap       <= '0;
      sh_hb        <= 8'd1;
      sh_step      <= '0;
      act_w        <= '0;
      act_h        <= '0;
      act_gap      <= '0;
      act_hb       <= 8'd1;
      scale_step_h <= '0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      gap_cnt      <= '0;
      blank_cnt    <= '0;
      lead_cnt     <= '0;
      di_o         <= '0;
      de_o         <= 1'b0;
      vs_o         <= 1'b1;
      busy         <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_w    <= cfg_w;
        sh_h    <= cfg_h;
        sh_gap  <= cfg_gap;
        sh_hb   <= cfg_hblank;
        sh_step <= cfg_step;
      end

      if (accept) begin
        act_w        <= sh_w;
        act_h        <= sh_h;
        act_gap      <= sh_gap;
        act_hb       <= (sh_hb == '0) ? 8'd1 : sh_hb;
        scale_step_h <= sh_step;
        line_cnt     <= '0;
        lead_cnt     <= LW'(VS_LEAD - 1);
        busy         <= 1'b1;
        vs_o         <= 1'b0;
      end

      if ((state == S_VLEAD) && (lead_cnt != '0)) lead_cnt <= lead_cnt - LW'(1);

      if (state == S_HS) begin
        pix_cnt <= '0;
        gap_cnt <= '0;
      end

      de_o <= fire;
      if (fire) begin
        di_o    <= src.src_data;
        pix_cnt <= pix_cnt + DIM_ONE;
        gap_cnt <= act_gap;
      end else if ((state == S_PIX) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 4'd1;
      end

      // Blank count runs one cycle longer than act_hb so that the last
      // pixel's delayed de_o is followed by act_hb genuinely empty cycles.
      if (fire && (state_nx == S_HBLANK)) blank_cnt <= act_hb;

      if (state == S_HBLANK) begin
        if (blank_cnt != '0)        blank_cnt <= blank_cnt - 8'd1;
        else if (state_nx == S_HS) line_cnt  <= line_cnt + DIM_ONE;
      end

      if ((state == S_HBLANK) && (state_nx == S_DONE)) vs_o <= 1'b1;
      if (state == S_DONE) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scaler_h_sched.sv
// Self-checking bench for scaler_h_sched: stimulus pushes the expected event
// stream of every accepted frame into a queue; a negedge monitor pops and
// compares whenever the DUT shows vs fall, hs, de or frame_done.
module tb_scaler_h_sched;
  localparam int PW = 8;
  localparam int DW = 12;
  localparam int VL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [DW-1:0] cfg_w = '0;
  logic [DW-1:0] cfg_h = '0;
  logic [3:0]    cfg_gap = '0;
  logic [7:0]    cfg_hblank = '0;
  logic [15:0]   cfg_step = '0;
  logic          start = 1'b0;
  logic [PW-1:0] di_o;
  logic          de_o, hs_o, vs_o, busy, frame_done;
  logic [15:0]   scale_step_h;

  always #5 clk = ~clk;

  scaler_h_sched_if #(.PIXEL_WIDTH(PW)) src_if();

  scaler_h_sched #(.PIXEL_WIDTH(PW), .DIM_WIDTH(DW), .VS_LEAD(VL)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_gap(cfg_gap), .cfg_hblank(cfg_hblank), .cfg_step(cfg_step),
    .start(start), .src(src_if), .di_o(di_o), .de_o(de_o), .hs_o(hs_o),
    .vs_o(vs_o), .scale_step_h(scale_step_h), .busy(busy), .frame_done(frame_done)
  );

  typedef enum int {K_VSF, K_HS, K_PIX, K_DONE} kind_t;
  typedef struct {
    kind_t kind;
    int    data;
    int    delta;
    bit    exact;
  } item_t;

  item_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;
  int done_cyc = -10;
  int mon_pix = 0;
  int exp_step = 0;
  bit frame_active = 1'b0;
  bit prev_vs = 1'b1;

  // Shadow-register model and source model
  int sh_w = 0, sh_h = 0, sh_gap = 0, sh_hb = 1, sh_step = 0;
  int src_cnt = 1;
  int src_mode = 0;
  int stall_left = 0;
  int stall_val = -1;
  bit pend = 1'b0;
  int rw, rh, rg, rb, rs, n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      failures++;
      $display("FAIL %s: got %0d expected at least %0d (cycle %0d)", name, act, min, cyc);
    end
  endtask

  task automatic pop_ev(input kind_t k, input int d);
    item_t it;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected no event", int'(k), cyc);
      return;
    end
    it = q.pop_front();
    check("event_kind", int'(k), int'(it.kind));
    if (k == K_PIX) check("pixel_data", d, it.data);
    if (it.exact) check("event_spacing", cyc - last_cyc, it.delta);
    else          check_ge("event_spacing_min", cyc - last_cyc, it.delta);
    check("scale_step_h", int'(scale_step_h), exp_step);
    check("busy_in_frame", int'(busy), 1);
    if (k == K_DONE) begin
      check("vs_at_done", int'(vs_o), 1);
      frame_active = 1'b0;
      done_cyc = cyc;
    end else begin
      check("vs_in_frame", int'(vs_o), 0);
    end
    if (k == K_VSF) mon_pix = 0;
    if (k == K_PIX) mon_pix++;
    last_cyc = cyc;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (hs_o || de_o || frame_done)
        check("outputs_exclusive", int'(hs_o) + int'(de_o) + int'(frame_done), 1);
      if (prev_vs && !vs_o) pop_ev(K_VSF, 0);
      if (hs_o)       pop_ev(K_HS, 0);
      if (de_o)       pop_ev(K_PIX, int'(di_o));
      if (frame_done) pop_ev(K_DONE, 0);
    end
    prev_vs = vs_o;
  end

  // Pixel source: value advances once per accepted handshake
  initial begin
    bit v;
    src_if.src_data  = '0;
    src_if.src_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) src_cnt++;
      src_if.src_data = PW'(src_cnt);
      if (stall_left > 0 && src_cnt == stall_val) begin
        v = 1'b0;
        stall_left--;
      end else if (src_mode == 1) begin
        v = ($urandom_range(0, 9) < 7);
      end else begin
        v = 1'b1;
      end
      src_if.src_valid = v;
      #3 pend = v && src_if.src_ready && !rst;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push_item(input kind_t k, input int d, input int dl, input bit ex);
    item_t it;
    it.kind = k; it.data = d; it.delta = dl; it.exact = ex;
    q.push_back(it);
  endtask

  task automatic push_frame(input bit stall);
    int hb_eff, idx, dl;
    bit ex;
    hb_eff = (sh_hb == 0) ? 1 : sh_hb;
    idx = 0;
    push_item(K_VSF, 0, 1, 1'b1);
    for (int l = 0; l < sh_h; l++) begin
      push_item(K_HS, 0, (l == 0) ? VL : hb_eff + 1, 1'b1);
      for (int p = 0; p < sh_w; p++) begin
        dl = (p == 0) ? 2 : sh_gap + 1;
        ex = (src_mode == 0);
        if (stall && idx == 1) dl = ((sh_gap > 5) ? sh_gap : 5) + 1;
        push_item(K_PIX, (src_cnt + idx) & 255, dl, ex);
        idx++;
      end
    end
    push_item(K_DONE, 0, hb_eff + 1, 1'b1);
  endtask

  task automatic drive_cfg(input int w, input int h, input int g, input int hb, input int s);
    cfg_w = DW'(w); cfg_h = DW'(h); cfg_gap = 4'(g); cfg_hblank = 8'(hb); cfg_step = 16'(s);
    cfg_wr = 1'b1;
  endtask

  task automatic set_shadow(input int w, input int h, input int g, input int hb, input int s);
    sh_w = w; sh_h = h; sh_gap = g; sh_hb = hb; sh_step = s;
  endtask

  task automatic do_cfg(input int w, input int h, input int g, input int hb, input int s);
    drive_cfg(w, h, g, hb, s);
    step();
    cfg_wr = 1'b0;
    set_shadow(w, h, g, hb, s);
  endtask

  task automatic do_start(input bit with_cfg, input int w, input int h, input int g,
                          input int hb, input int s, input bit stall);
    start = 1'b1;
    if (with_cfg) drive_cfg(w, h, g, hb, s);
    if (!frame_active && cyc > done_cyc && sh_w != 0 && sh_h != 0) begin
      if (stall) begin
        stall_left = 5;
        stall_val  = src_cnt + 1;
      end
      push_frame(stall);
      frame_active = 1'b1;
      exp_step = sh_step;
      last_cyc = cyc;
    end
    step();
    start = 1'b0;
    cfg_wr = 1'b0;
    if (with_cfg) set_shadow(w, h, g, hb, s);
  endtask

  task automatic model_reset();
    q.delete();
    frame_active = 1'b0;
    set_shadow(0, 0, 0, 1, 0);
    exp_step = 0;
    stall_left = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_src_ready", int'(src_if.src_ready), 0);
    check("rst_di_o", int'(di_o), 0);
    check("rst_de_o", int'(de_o), 0);
    check("rst_hs_o", int'(hs_o), 0);
    check("rst_vs_o", int'(vs_o), 1);
    check("rst_scale_step_h", int'(scale_step_h), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (frame_active && k < budget) begin
      step();
      k++;
    end
    if (frame_active) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: still active after %0d cycles, expected frame_done", budget);
      rst = 1'b1;
      step();
      step();
      model_reset();
      rst = 1'b0;
      step();
    end else begin
      step();
      check("busy_after_done", int'(busy), 0);
      check("vs_after_done", int'(vs_o), 1);
      check("queue_drained", q.size(), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step(); step();
    check_reset_outputs();
    rst = 1'b0;
    step();

    // Basic frame, mid-frame cfg write and an ignored start while busy
    src_mode = 0;
    do_cfg(4, 2, 0, 2, 171);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
    repeat (6) step();
    do_cfg(4, 2, 0, 2, 96);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle(500);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
    check("step_after_new_start", int'(scale_step_h), 96);
    wait_idle(500);

    // Pixel gap patterns
    do_cfg(3, 2, 1, 1, 7);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle(500);
    do_cfg(3, 1, 3, 0, 8);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle(500);

    // Source stall before pixel 2
    do_cfg(4, 2, 0, 3, 9);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b1);
    wait_idle(500);

    // Zero height: start must be ignored
    do_cfg(4, 0, 0, 1, 5);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("h0_busy", int'(busy), 0);
      check("h0_vs", int'(vs_o), 1);
      step();
    end

    // cfg_wr together with start: old shadow is used for this frame
    do_cfg(2, 1, 0, 1, 10);
    do_start(1'b1, 3, 2, 1, 2, 20, 1'b0);
    wait_idle(500);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle(500);

    // Reset in the middle of line 1
    do_cfg(4, 3, 0, 1, 55);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
    n = 0;
    while (mon_pix < 6 && n < 500) begin
      step();
      n++;
    end
    check_ge("reached_line1_pixel2", mon_pix, 6);
    rst = 1'b1;
    step();
    check_reset_outputs();
    model_reset();
    rst = 1'b0;
    step();
    do_cfg(3, 2, 0, 1, 33);
    do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle(500);

    // Randomized frames
    for (int i = 0; i < 25; i++) begin
      rw = $urandom_range(1, 6);
      rh = $urandom_range(1, 3);
      rg = $urandom_range(0, 3);
      rb = $urandom_range(0, 4);
      rs = $urandom_range(0, 65535);
      src_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
        1: begin
          do_cfg(rw, rh, rg, rb, rs);
          do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
        end
        default: do_start(1'b1, rw, rh, rg, rb, rs, 1'b0);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        repeat (3) step();
        do_start(1'b0, 0, 0, 0, 0, 0, 1'b0);
      end
      wait_idle(3000);
    end

    repeat (4) step();
    check("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scaler_h_sched.md
Name: scaler_h_sched

Overview:
- Frame/line sequencer that drives the input stream of the horizontal scaler (di/de/hs/vs) from a valid/ready pixel source.
- Inserts a programmable per-pixel gap and inter-line blanking, and generates the hs line-start pulse and the active-low vs frame envelope.
- Owns the scale_step_h configuration: a host writes a shadow register, which is applied only at frame start, so the scaler never sees a mid-frame step change.

Parameters:
PIXEL_WIDTH, 8, pixel data width
DIM_WIDTH, 12, width of line length / line count fields
VS_LEAD, 4, cycles between vs_o falling and first hs_o pulse (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_wr  in  1  write strobe, loads all cfg_* into shadow regs
cfg_w  in  DIM_WIDTH  pixels per line
cfg_h  in  DIM_WIDTH  lines per frame
cfg_gap  in  4  empty cycles between issued pixels (0 = back-to-back)
cfg_hblank  in  8  blank cycles after each line (0 treated as 1)
cfg_step  in  16  scale step (PIXEL_STEP units)
start  in  1  one-cycle frame request
src_data  in  PIXEL_WIDTH  source pixel
src_valid  in  1  source pixel valid
src_ready  out  1  pixel accepted when src_valid & src_ready
di_o  out  PIXEL_WIDTH  pixel to scaler
de_o  out  1  pixel valid to scaler
hs_o  out  1  one-cycle line-start pulse
vs_o  out  1  low while frame active
scale_step_h  out  16  active step to scaler
busy  out  1  high from accepted start to end of frame_done
frame_done  out  1  one-cycle pulse after last line's blanking

Behaviour:
- Reset values: src_ready=0, di_o=0, de_o=0, hs_o=0, vs_o=1, scale_step_h=0, busy=0, frame_done=0. Shadow regs: w=0, h=0, gap=0, hblank=1, step=0. Reset mid-frame returns to IDLE at that edge and drops the frame; the source is not drained.
- cfg_wr is accepted in any state and updates the shadow regs only. Active regs (w, h, gap, hblank, scale_step_h) are copied from shadow on an accepted start. A cfg_wr and start in the same cycle: start uses the old shadow values; the new values apply to the next frame.
- FSM:
  - IDLE:
    - start with shadow w!=0 and h!=0: latch active regs, busy=1, vs_o=0 next cycle, go to VLEAD.
    - start with w==0 or h==0: ignored, no busy, no frame_done.
    - start in any state other than IDLE: ignored.
  - VLEAD: VS_LEAD cycles, then go to HS.
  - HS: hs_o=1 for exactly one cycle; clear pixel count; gap counter=0; go to PIX.
  - PIX:
    - src_ready = (gap counter==0) & (pix count<w).
    - On handshake: di_o<=src_data and de_o<=1 on the next cycle (1-cycle latency); pix count+1; gap counter<=gap.
    - No handshake: de_o<=0, di_o holds; gap counter decrements if nonzero.
    - src_valid low at an issue slot: wait with no timeout; the gap counter stays 0.
    - After the handshake making count==w, go to HBLANK; src_ready is 0 from that cycle.
  - HBLANK: max(hblank,1) cycles with de_o=0. Then: line count+1 < h → HS; else → DONE.
  - DONE: vs_o<=1, frame_done=1 for one cycle, busy<=0 together, go to IDLE. A start in the cycle after DONE is accepted.
- hs_o, de_o and frame_done are never high together; hs_o is never high while vs_o=1.
- scale_step_h is constant from one cycle after start acceptance until the next accepted start.
- Counters are DIM_WIDTH unsigned with no wrap: pix count is bounded by w and line count by h.

Test Plan:
- Shadow w=4, h=2, gap=0, hblank=2, step=171; source always valid with data 1,2,3…:
  - vs_o low 1 cycle after start; hs_o pulse VS_LEAD cycles later.
  - de_o high 4 consecutive cycles with di_o=1..4; 2 blank cycles; hs_o; di_o=5..8.
  - frame_done 1 cycle after the second blanking; vs_o=1 on the same edge; scale_step_h=171 throughout.
- gap=1, w=3: de_o pattern per line is 1,0,1,0,1 with data 1..3.
- gap=3, w=3: de_o asserts every 4th cycle; 3 pixels per line.
- Source stall: src_valid low for 5 cycles before pixel 2 → de_o low for those 5 cycles; pixel order and count preserved; line still emits exactly w pixels.
- Config timing:
  - cfg_wr with step=96 mid-frame → scale_step_h stays 171 until frame end, becomes 96 one cycle after the next start.
  - start during busy → ignored, exactly one frame_done.
  - start with h=0 → busy stays 0, vs_o stays 1.
- Reset mid-line (after pixel 2 of line 1): next cycle all outputs at reset values and FSM in IDLE; a new start produces a complete frame from line 0.
